regfile_write_queue: RTL and testbench
======================================

REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending write entries (power of two, >=2).
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter ADDR_W, default 5, register address width (32 registers).
REQ-004 One clock, port clock; reset port ctrl_reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock, all state updates on rising edge.
REQ-006 ctrl_reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  producer offers a write-back request.
REQ-008 in_ready  output  1  queue can accept a request this cycle.
REQ-009 in_reg  input  ADDR_W  destination register of the request.
REQ-010 in_data  input  DATA_W  data to write.
REQ-011 wr_stall  input  1  register file write port unavailable this cycle.
REQ-012 ctrl_writeEnable  output  1  write strobe to register file.
REQ-013 ctrl_writeReg  output  ADDR_W  register file write address.
REQ-014 data_writeReg  output  DATA_W  register file write data.
REQ-015 query_reg  input  ADDR_W  read-side lookup address.
REQ-016 query_hit  output  1  a pending entry targets query_reg.
REQ-017 query_data  output  DATA_W  data of newest pending entry matching query_reg.
REQ-018 count  output  $clog2(DEPTH)+1  number of pending entries.

Function
REQ-019 in_ready SHALL equal (count < DEPTH); no pass-through when full, even if a pop occurs that cycle.
REQ-020 A request SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-021 An accepted request with in_reg == 0 SHALL be discarded (not enqueued, count unchanged).
REQ-022 An accepted nonzero request SHALL be written at the tail; the tail pointer advances modulo DEPTH.
REQ-023 ctrl_writeEnable SHALL be high combinationally iff count != 0 and wr_stall == 0; ctrl_writeReg/data_writeReg SHALL show the head entry whenever count != 0, else zero.
REQ-024 A cycle with ctrl_writeEnable high SHALL pop the head at the next edge; the head pointer wraps modulo DEPTH.
REQ-025 Minimum latency: request accepted at edge N appears on the write port in the cycle following edge N.
REQ-026 Entries SHALL drain strictly in acceptance order, one per cycle maximum.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; push-only adds 1, pop-only subtracts 1.
REQ-028 query_hit SHALL be high iff query_reg != 0 and any pending entry (including the head being popped this cycle) matches; a request being accepted in the same cycle is not visible.
REQ-029 On multiple matches query_data SHALL return the most recently accepted matching entry; query_data SHALL be zero when query_hit is low.
REQ-030 wr_stall held high SHALL freeze the head; acceptance continues until full.

Reset
REQ-031 While ctrl_reset is high at an edge: head, tail and count go to 0, all pending entries are dropped, in_ready = 1 from the following cycle.
REQ-032 After reset ctrl_writeEnable, ctrl_writeReg, data_writeReg, query_hit, query_data and count SHALL all be 0.
REQ-033 Reset mid-drain SHALL suppress all further writes of pre-reset entries; a request presented in the reset cycle is not accepted.

Structure
REQ-034 ADDR_W, DATA_W, NUM_REGS (32) and ZERO_REG (0) SHALL live in the shared package regfile_pkg.
REQ-035 Entry storage with head/tail pointers and count SHALL be one sub-module, regfile_wq_storage; lookup and port logic stay in the top.

Verification
REQ-036 Push reg 3 = 0xDEADBEEF, wr_stall=0 -> next cycle ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=0xDEADBEEF, then count=0.
REQ-037 wr_stall=1, push regs 1,2,3,4,5 back-to-back -> 4 accepted, in_ready=0 on the 5th, count=4; release stall -> writes 1,2,3,4 in consecutive cycles.
REQ-038 Push reg 0 = 0x12345678 -> in_ready handshake completes, count stays 0, no write strobe.
REQ-039 Stall, push reg 7 = 0x1 then reg 7 = 0x2, query_reg=7 -> query_hit=1, query_data=0x2; query_reg=0 -> query_hit=0.
REQ-040 Full queue, stall released, in_valid=1 continuously for 12 cycles -> one push and one pop per cycle once not full, pointers wrap, order preserved.
REQ-041 Queue holding 3 entries, assert ctrl_reset for one cycle -> count=0, no further ctrl_writeEnable, in_ready=1 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file geometry used by the write-back queue and its neighbours.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_pkg;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = $clog2(NUM_REGS);
   localparam int DATA_W   = 32;
   // Writes to the hard-wired zero register are architecturally meaningless.
   localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_wq_storage.sv
// Circular store of pending write-back entries with head/tail pointers and occupancy count.
// Latency: a push is visible in the slot arrays and count on the cycle after its edge.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
module regfile_wq_storage #(
   parameter int  DEPTH  = 4,
   parameter int  DATA_W = 32,
   parameter int  ADDR_W = 5,
   localparam int PW     = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH) + 1
)(
   input  logic                          clock,
   input  logic                          ctrl_reset,
   input  logic                          push,
   input  logic [ADDR_W-1:0]             push_reg,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [PW-1:0]                 head_ptr,
   output logic [CW-1:0]                 count,
   output logic [DEPTH-1:0][ADDR_W-1:0]  slot_reg,
   output logic [DEPTH-1:0][DATA_W-1:0]  slot_data
);

   logic [PW-1:0] tail_ptr;

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + PW'(1);
         if (pop)  head_ptr <= head_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payload; stale slots need no clearing because count bounds every reader.
   always_ff @(posedge clock) begin
      if (push && !ctrl_reset) begin
         slot_reg[tail_ptr]  <= push_reg;
         slot_data[tail_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// Write-back queue in front of a single register-file write port, with bypass lookup of pending data.
// Latency: an accepted request reaches the write port in the cycle after its accept edge.
// Backpressure: in_ready drops when DEPTH entries are pending; wr_stall freezes the head.
module regfile_write_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
)(
   input  logic                      clock,
   input  logic                      ctrl_reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_reg,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      wr_stall,
   output logic                      ctrl_writeEnable,
   output logic [ADDR_W-1:0]         ctrl_writeReg,
   output logic [DATA_W-1:0]         data_writeReg,
   input  logic [ADDR_W-1:0]         query_reg,
   output logic                      query_hit,
   output logic [DATA_W-1:0]         query_data,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(regfile_pkg::ZERO_REG);

   logic                         push;
   logic                         pop;
   logic                         not_empty;
   logic [PW-1:0]                head_ptr;
   logic [DEPTH-1:0][ADDR_W-1:0] slot_reg;
   logic [DEPTH-1:0][DATA_W-1:0] slot_data;

   // Full means full: a pop in the same cycle does not open a slot for pass-through.
   assign in_ready  = (count < CW'(DEPTH));
   assign not_empty = (count != '0);

   // Zero-register requests complete the handshake but are dropped here.
   assign push = in_valid && in_ready && (in_reg != ZERO_ADDR);
   assign pop  = ctrl_writeEnable;

   regfile_wq_storage #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_storage (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .push       (push),
      .push_reg   (in_reg),
      .push_data  (in_data),
      .pop        (pop),
      .head_ptr   (head_ptr),
      .count      (count),
      .slot_reg   (slot_reg),
      .slot_data  (slot_data)
   );

   // Write port shows the head entry whenever one is pending, zero otherwise.
   always_comb begin
      ctrl_writeEnable = not_empty && !wr_stall;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      if (not_empty) begin
         ctrl_writeReg = slot_reg[head_ptr];
         data_writeReg = slot_data[head_ptr];
      end
   end

   // Bypass lookup: walk oldest to newest so the newest matching entry wins.
   always_comb begin
      query_hit  = 1'b0;
      query_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count) && (query_reg != ZERO_ADDR) &&
             (slot_reg[head_ptr + PW'(i)] == query_reg)) begin
            query_hit  = 1'b1;
            query_data = slot_data[head_ptr + PW'(i)];
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for the register-file write-back queue.
// Latency: inputs driven and outputs sampled 1-2 time units after each rising edge.
// Backpressure: exercised through wr_stall and a full queue.
module tb_regfile_write_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clock;
   logic              ctrl_reset;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_reg;
   logic [DATA_W-1:0] in_data;
   logic              wr_stall;
   logic              ctrl_writeEnable;
   logic [ADDR_W-1:0] ctrl_writeReg;
   logic [DATA_W-1:0] data_writeReg;
   logic [ADDR_W-1:0] query_reg;
   logic              query_hit;
   logic [DATA_W-1:0] query_data;
   logic [2:0]        count;

   int n_tests;
   int n_fail;

   regfile_write_queue #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_reg           (in_reg),
      .in_data          (in_data),
      .wr_stall         (wr_stall),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .query_reg        (query_reg),
      .query_hit        (query_hit),
      .query_data       (query_data),
      .count            (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      ctrl_reset = 1'b1;
      in_valid   = 1'b0;
      in_reg     = '0;
      in_data    = '0;
      wr_stall   = 1'b0;
      query_reg  = '0;
      tick();
      tick();
      ctrl_reset = 1'b0;
      #1;

      // Reset state
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_we", ctrl_writeEnable, 0);
      chk("rst_wreg", ctrl_writeReg, 0);
      chk("rst_wdata", data_writeReg, 0);
      chk("rst_qhit", query_hit, 0);
      chk("rst_qdata", query_data, 0);

      // Single push, minimum latency, head visible to lookup
      in_valid = 1'b1; in_reg = 5'd3; in_data = 32'hDEADBEEF;
      tick();
      in_valid = 1'b0; query_reg = 5'd3;
      #1;
      chk("one_count", count, 1);
      chk("one_we", ctrl_writeEnable, 1);
      chk("one_wreg", ctrl_writeReg, 3);
      chk("one_wdata", data_writeReg, 32'hDEADBEEF);
      chk("one_qhit", query_hit, 1);
      chk("one_qdata", query_data, 32'hDEADBEEF);
      tick();
      chk("one_drained_count", count, 0);
      chk("one_drained_we", ctrl_writeEnable, 0);
      chk("one_drained_wreg", ctrl_writeReg, 0);
      chk("one_drained_qhit", query_hit, 0);

      // Zero-register request is accepted and dropped
      in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h12345678;
      #1;
      chk("zero_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("zero_count", count, 0);
      chk("zero_we", ctrl_writeEnable, 0);

      // Stalled fill: 4 accepted, 5th refused
      wr_stall = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1; in_reg = ADDR_W'(k); in_data = DATA_W'(k * 32'h11);
         #1;
         chk($sformatf("fill_in_ready_%0d", k), in_ready, (k <= 4) ? 1 : 0);
         tick();
      end
      in_valid = 1'b0;
      #1;
      chk("fill_count", count, 4);
      chk("fill_we_stalled", ctrl_writeEnable, 0);
      chk("fill_head_reg", ctrl_writeReg, 1);
      wr_stall = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk($sformatf("drain_we_%0d", k), ctrl_writeEnable, 1);
         chk($sformatf("drain_wreg_%0d", k), ctrl_writeReg, k);
         chk($sformatf("drain_wdata_%0d", k), data_writeReg, k * 32'h11);
         tick();
      end
      chk("drain_count", count, 0);
      chk("drain_we_idle", ctrl_writeEnable, 0);

      // Lookup: newest match wins, zero query misses, same-cycle push invisible
      wr_stall = 1'b1;
      in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h1;
      tick();
      in_reg = 5'd7; in_data = 32'h2;
      tick();
      in_valid = 1'b0; query_reg = 5'd7;
      #1;
      chk("q7_hit", query_hit, 1);
      chk("q7_data", query_data, 32'h2);
      query_reg = 5'd0;
      #1;
      chk("q0_hit", query_hit, 0);
      chk("q0_data", query_data, 0);
      query_reg = 5'd5;
      #1;
      chk("q5_miss", query_hit, 0);
      query_reg = 5'd9; in_valid = 1'b1; in_reg = 5'd9; in_data = 32'h99;
      #1;
      chk("q9_same_cycle_hit", query_hit, 0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("q9_hit", query_hit, 1);
      chk("q9_data", query_data, 32'h99);
      chk("q_count", count, 3);

      // Reset with 3 pending entries and a request offered in the reset cycle
      wr_stall = 1'b0; ctrl_reset = 1'b1;
      in_valid = 1'b1; in_reg = 5'd4; in_data = 32'h44;
      tick();
      ctrl_reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("mrst_count", count, 0);
      chk("mrst_we", ctrl_writeEnable, 0);
      chk("mrst_in_ready", in_ready, 1);
      chk("mrst_qhit", query_hit, 0);
      tick();
      chk("mrst_count_after", count, 0);
      chk("mrst_we_after", ctrl_writeEnable, 0);

      // Full queue, stall released, continuous offers: push+pop each cycle, pointers wrap
      wr_stall = 1'b1;
      for (int k = 10; k <= 13; k++) begin
         in_valid = 1'b1; in_reg = ADDR_W'(k); in_data = DATA_W'(32'h100 + k);
         tick();
      end
      in_valid = 1'b0;
      #1;
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      wr_stall = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1;
         in_reg   = ADDR_W'((c == 0) ? 14 : 13 + c);
         in_data  = DATA_W'(32'h100 + ((c == 0) ? 14 : 13 + c));
         #1;
         chk($sformatf("stream_we_%0d", c), ctrl_writeEnable, 1);
         chk($sformatf("stream_wreg_%0d", c), ctrl_writeReg, 10 + c);
         chk($sformatf("stream_wdata_%0d", c), data_writeReg, 32'h100 + 10 + c);
         chk($sformatf("stream_count_%0d", c), count, (c == 0) ? 4 : 3);
         chk($sformatf("stream_in_ready_%0d", c), in_ready, (c == 0) ? 0 : 1);
         tick();
      end
      in_valid = 1'b0;
      for (int k = 22; k <= 24; k++) begin
         #1;
         chk($sformatf("tail_wreg_%0d", k), ctrl_writeReg, k);
         chk($sformatf("tail_wdata_%0d", k), data_writeReg, 32'h100 + k);
         tick();
      end
      chk("final_count", count, 0);
      chk("final_we", ctrl_writeEnable, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
